adsr_envelope: RTL

Per-sample ADSR amplitude envelope that sits directly downstream of the oscillator select mux in the synth top. It consumes the selected 24-bit signed waveform sample and the keypad gate (key pressed), and produces the enveloped sample for the audio output path. This replaces the hard on/off keying with attack/decay/sustain/release shaping. One sample is processed per `clk_48kHz` cycle.

---
 rtl/synth_pkg.sv | 17 +
 rtl/env_scale.sv | 24 ++
 rtl/adsr_envelope.sv | 136 +++++++++++++
 3 files changed

// File: rtl/synth_pkg.sv
// Shared synth types and constants: envelope FSM state encoding and default widths.
package synth_pkg;

  localparam int unsigned SAMPLE_W = 24;
  localparam int unsigned ENV_W    = 16;

  localparam logic [ENV_W-1:0] ENV_MAX = '1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } adsr_state_e;

endpackage

// File: rtl/env_scale.sv
// Registered signed sample x unsigned envelope level, scaled back down by the level width.
module env_scale #(
  parameter int unsigned width_p     = 24,
  parameter int unsigned env_width_p = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic signed [width_p-1:0] sample,
  input  logic [env_width_p-1:0]    level,
  output logic signed [width_p-1:0] scaled
);

  localparam int unsigned PROD_W = width_p + env_width_p + 1;

  // Level is zero-extended so the multiply stays signed; truncation drops the top guard bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scaled <= '0;
    end else begin
      scaled <= width_p'((PROD_W'(sample) * $signed(PROD_W'({1'b0, level}))) >>> env_width_p);
    end
  end

endmodule

// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope: level FSM plus registered sample scaling.
// Optional macro ADSR_GATE_SYNC_EN adds a 2-flop synchronizer on gate_i.
module adsr_envelope
  import synth_pkg::*;
#(
  parameter int unsigned width_p     = SAMPLE_W,
  parameter int unsigned env_width_p = ENV_W
) (
  input  logic                      clk_48kHz,
  input  logic                      rst_n,
  input  logic                      gate_i,
  input  logic signed [width_p-1:0] sample_i,
  input  logic [env_width_p-1:0]    attack_rate_i,
  input  logic [env_width_p-1:0]    decay_rate_i,
  input  logic [env_width_p-1:0]    sustain_level_i,
  input  logic [env_width_p-1:0]    release_rate_i,
  output logic signed [width_p-1:0] sample_o,
  output logic [env_width_p-1:0]    level_o,
  output logic [2:0]                state_o,
  output logic                      active_o
);

  localparam int unsigned EXT_W = env_width_p + 1;
  localparam logic [env_width_p-1:0] LVL_MAX = '1;

  adsr_state_e            state, state_n;
  logic [env_width_p-1:0] level, level_n;
  logic [env_width_p-1:0] att_eff, dec_eff, rel_eff;
  logic [EXT_W-1:0]       att_sum, dec_floor;
  logic                   gate;

`ifdef ADSR_GATE_SYNC_EN
  logic [1:0] gate_sync;

  always_ff @(posedge clk_48kHz or negedge rst_n) begin
    if (!rst_n) begin
      gate_sync <= '0;
    end else begin
      gate_sync <= {gate_sync[0], gate_i};
    end
  end

  assign gate = gate_sync[1];
`else
  assign gate = gate_i;
`endif

  // A zero rate would stall the envelope, so it is bumped to one step per cycle.
  always_comb begin
    att_eff = (attack_rate_i  == '0) ? env_width_p'(1) : attack_rate_i;
    dec_eff = (decay_rate_i   == '0) ? env_width_p'(1) : decay_rate_i;
    rel_eff = (release_rate_i == '0) ? env_width_p'(1) : release_rate_i;
  end

  always_comb begin
    state_n   = state;
    level_n   = level;
    att_sum   = {1'b0, level} + {1'b0, att_eff};
    dec_floor = {1'b0, sustain_level_i} + {1'b0, dec_eff};
    case (state)
      IDLE: begin
        level_n = '0;
        if (gate) state_n = ATTACK;
      end
      ATTACK: begin
        if (!gate) begin
          state_n = RELEASE;
        end else if (att_sum >= {1'b0, LVL_MAX}) begin
          level_n = LVL_MAX;
          state_n = DECAY;
        end else begin
          level_n = att_sum[env_width_p-1:0];
        end
      end
      DECAY: begin
        if (!gate) begin
          state_n = RELEASE;
        end else if ({1'b0, level} <= dec_floor) begin
          level_n = sustain_level_i;
          state_n = SUSTAIN;
        end else begin
          level_n = level - dec_eff;
        end
      end
      SUSTAIN: begin
        if (!gate) begin
          state_n = RELEASE;
        end else begin
          level_n = sustain_level_i;
        end
      end
      RELEASE: begin
        // Retrigger keeps the current level so the attack ramps from there.
        if (gate) begin
          state_n = ATTACK;
        end else if (level <= rel_eff) begin
          level_n = '0;
          state_n = IDLE;
        end else begin
          level_n = level - rel_eff;
        end
      end
      default: begin
        state_n = IDLE;
        level_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk_48kHz or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      level    <= '0;
      active_o <= 1'b0;
    end else begin
      state    <= state_n;
      level    <= level_n;
      active_o <= (state_n != IDLE);
    end
  end

  assign state_o = state;
  assign level_o = level;

  env_scale #(
    .width_p     (width_p),
    .env_width_p (env_width_p)
  ) u_env_scale (
    .clk    (clk_48kHz),
    .rst_n  (rst_n),
    .sample (sample_i),
    .level  (level),
    .scaled (sample_o)
  );

endmodule
